// File: rtl/data_mem_mmio.sv
// data_mem_mmio: data-side word RAM plus LED, timer and TX FIFO registers behind addr[31]
// Ports:
//   clk, reset (async, active-low)
//   mem_write, addr, wr_data : store strobe, byte address, store data from the core
//   rd_data                  : combinational load data for addr
//   led                      : LED register
//   timer_irq                : timer match flag (level)
//   tx_valid, tx_data        : FIFO head, drained when tx_ready is high
module data_mem_mmio #(
  parameter int MEM_WORDS = 64,
  parameter int TX_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic [31:0] led,
  output logic        timer_irq,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready
);
  localparam int AW = $clog2(MEM_WORDS);
  localparam int PW = $clog2(TX_DEPTH);
  localparam int CW = PW + 1;
  logic [31:0] ram [MEM_WORDS];
  logic [7:0] fifo [TX_DEPTH];
  logic [31:0] count, compare, mmio_rd, txstat;
  logic flag, ovf, mmio, full, empty, pop, push, accept, unused;
  logic [2:0] sel;
  logic [7:0] wr_reg;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] cnt;
  assign mmio = addr[31];
  assign sel = addr[4:2];
  // one write strobe per MMIO register slot
  assign wr_reg = (mem_write && mmio) ? 8'b1 << sel : 8'b0;
  assign full = cnt == CW'(TX_DEPTH);
  assign empty = cnt == '0;
  assign pop = tx_valid & tx_ready;
  assign push = wr_reg[4];
  // a full FIFO still takes a push when the head leaves in the same cycle
  assign accept = push & (~full | pop);
  assign tx_valid = ~empty;
  assign tx_data = empty ? 8'h00 : fifo[rd_ptr];
  assign timer_irq = flag;
  assign txstat = {24'b0, 4'(cnt), 1'b0, ovf, empty, full};
  assign unused = ^{addr[30:AW+2], addr[1:0]};
  always_comb begin
    mmio_rd = sel == 3'd0 ? led :
              sel == 3'd1 ? count :
              sel == 3'd2 ? compare :
              sel == 3'd3 ? {31'b0, flag} :
              sel == 3'd5 ? txstat : 32'b0;
    rd_data = mmio ? mmio_rd : ram[addr[AW+1:2]];
  end
  always_ff @(posedge clk) begin
    if (mem_write && !mmio) ram[addr[AW+1:2]] <= wr_data;
  end
  always_ff @(posedge clk) begin
    if (accept) fifo[wr_ptr] <= wr_data[7:0];
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      led <= '0;
      count <= '0;
      compare <= '0;
      flag <= 1'b0;
      ovf <= 1'b0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt <= '0;
    end else begin
      if (wr_reg[0]) led <= wr_data;
      count <= wr_reg[1] ? wr_data : count + 32'd1;
      if (wr_reg[2]) compare <= wr_data;
      // a match in the same cycle as a clear wins
      flag <= (count == compare) | (flag & ~(wr_reg[3] & wr_data[0]));
      ovf <= (push & ~accept) | (ovf & ~(wr_reg[5] & wr_data[2]));
      if (accept) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      cnt <= cnt + CW'(accept) - CW'(pop);
    end
  end
endmodule

// File: tb/tb_data_mem_mmio.sv
// tb_data_mem_mmio: randomized and directed bench for data_mem_mmio against a queue-based model
module tb_data_mem_mmio;
  localparam logic [31:0] LED = 32'h8000_0000, CNT = 32'h8000_0004, CMP = 32'h8000_0008,
                          TST = 32'h8000_000C, TXD = 32'h8000_0010, TXS = 32'h8000_0014;
  logic clk = 0, reset = 0, mem_write = 0, tx_ready = 0;
  logic [31:0] addr = 0, wr_data = 0;
  logic [31:0] rd_data, led;
  logic timer_irq, tx_valid;
  logic [7:0] tx_data;
  int total = 0, bad = 0;
  logic [31:0] mram [64];
  logic [31:0] m_led, m_count, m_cmp;
  bit m_flag, m_ovf;
  logic [7:0] mq [$];

  data_mem_mmio #(.MEM_WORDS(64), .TX_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .mem_write(mem_write), .addr(addr), .wr_data(wr_data),
    .rd_data(rd_data), .led(led), .timer_irq(timer_irq), .tx_valid(tx_valid),
    .tx_data(tx_data), .tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] exp_rd(input logic [31:0] a);
    int off;
    if (!a[31]) return mram[(a % 256) / 4];
    off = int'((a % 32) / 4);
    case (off)
      0: return m_led;
      1: return m_count;
      2: return m_cmp;
      3: return {31'b0, m_flag};
      5: return 32'(mq.size() * 16 + int'(m_ovf) * 4 + (mq.size() == 0 ? 2 : 0) + (mq.size() == 4 ? 1 : 0));
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_led = 0; m_count = 0; m_cmp = 0; m_flag = 0; m_ovf = 0;
    mq.delete();
  endtask

  task automatic drive(input bit w, input logic [31:0] a, input logic [31:0] d, input bit r);
    mem_write = w; addr = a; wr_data = d; tx_ready = r;
  endtask

  task automatic tick();
    bit w, r, mm, pop, push, ok, hit;
    logic [31:0] a, d;
    int off;
    @(posedge clk);
    w = mem_write; a = addr; d = wr_data; r = tx_ready;
    mm = a[31]; off = int'((a % 32) / 4);
    hit = (m_count == m_cmp);
    pop = r && mq.size() > 0;
    push = w && mm && off == 4;
    ok = mq.size() < 4 || pop;
    if (w && !mm) mram[(a % 256) / 4] = d;
    if (w && mm && off == 0) m_led = d;
    if (w && mm && off == 2) m_cmp = d;
    m_count = (w && mm && off == 1) ? d : m_count + 1;
    if (hit) m_flag = 1;
    else if (w && mm && off == 3 && d[0]) m_flag = 0;
    if (pop) void'(mq.pop_front());
    if (push && ok) mq.push_back(d[7:0]);
    if (push && !ok) m_ovf = 1;
    if (w && mm && off == 5 && d[2]) m_ovf = 0;
    @(negedge clk);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input bit r);
    drive(1, a, d, r);
    tick();
  endtask

  task automatic test_reset();
    model_reset();
    drive(0, CNT, 0, 0);
    #12;
    total++; if (led !== 0) begin bad++; $display("FAIL reset_led got=%h exp=0", led); end
    total++; if (timer_irq !== 0) begin bad++; $display("FAIL reset_irq got=%b exp=0", timer_irq); end
    total++; if (tx_valid !== 0) begin bad++; $display("FAIL reset_txv got=%b exp=0", tx_valid); end
    total++; if (tx_data !== 0) begin bad++; $display("FAIL reset_txd got=%h exp=0", tx_data); end
    total++; if (rd_data !== 0) begin bad++; $display("FAIL reset_count got=%h exp=0", rd_data); end
    addr = TXS; #1;
    total++; if (rd_data !== 32'h2) begin bad++; $display("FAIL reset_txstat got=%h exp=2", rd_data); end
    @(negedge clk);
    reset = 1;
    drive(0, CNT, 0, 0); #1;
    total++; if (rd_data !== 0) begin bad++; $display("FAIL release_count0 got=%h exp=0", rd_data); end
    tick(); #1;
    total++; if (rd_data !== 32'd1) begin bad++; $display("FAIL release_count1 got=%h exp=1", rd_data); end
  endtask

  task automatic test_ram();
    logic [31:0] a;
    wr(32'h10, 32'hDEADBEEF, 0);
    drive(0, 32'h10, 0, 0); #1;
    total++; if (rd_data !== 32'hDEADBEEF) begin bad++; $display("FAIL ram_load got=%h exp=deadbeef", rd_data); end
    addr = 32'h10 + 4 * 64; #1;
    total++; if (rd_data !== 32'hDEADBEEF) begin bad++; $display("FAIL ram_alias got=%h exp=deadbeef", rd_data); end
    for (int i = 0; i < 64; i++) wr(i * 4 + (i % 2 == 1 ? 32'h1234_0000 : 0) + $urandom_range(0, 3), $urandom, 0);
    for (int i = 0; i < 16; i++) begin
      a = $urandom & 32'h7FFF_FFFF;
      drive(0, a, 0, 0); #1;
      total++; if (rd_data !== exp_rd(a)) begin bad++; $display("FAIL ram_rand a=%h got=%h exp=%h", a, rd_data, exp_rd(a)); end
      tick();
    end
  endtask

  task automatic test_led();
    wr(LED, 32'hA5, 0); #1;
    total++; if (led !== 32'hA5) begin bad++; $display("FAIL led_out got=%h exp=a5", led); end
    drive(0, LED, 0, 0); #1;
    total++; if (rd_data !== 32'hA5) begin bad++; $display("FAIL led_read got=%h exp=a5", rd_data); end
    wr(32'h8000_0018, 32'hFFFF_FFFF, 0);
    wr(32'h8000_001C, 32'hFFFF_FFFF, 0);
    drive(0, 32'h8000_0018, 0, 0); #1;
    total++; if (rd_data !== 0) begin bad++; $display("FAIL rd_18 got=%h exp=0", rd_data); end
    addr = 32'h8000_001C; #1;
    total++; if (rd_data !== 0) begin bad++; $display("FAIL rd_1c got=%h exp=0", rd_data); end
    addr = TXD; #1;
    total++; if (rd_data !== 0) begin bad++; $display("FAIL rd_txdata got=%h exp=0", rd_data); end
    addr = LED; #1;
    total++; if (rd_data !== 32'hA5) begin bad++; $display("FAIL led_kept got=%h exp=a5", rd_data); end
  endtask

  task automatic test_timer();
    int n;
    wr(CMP, 20, 0);
    wr(TST, 1, 0);
    wr(CNT, 15, 0); #1;
    total++; if (timer_irq !== 0) begin bad++; $display("FAIL irq_pre got=%b exp=0", timer_irq); end
    n = 0;
    while (n < 12) begin
      drive(0, CNT, 0, 0); #1;
      total++; if (rd_data !== exp_rd(CNT)) begin bad++; $display("FAIL count_read got=%h exp=%h", rd_data, exp_rd(CNT)); end
      tick(); n++;
      if (timer_irq) break;
    end
    total++; if (n !== 6) begin bad++; $display("FAIL irq_delay got=%0d exp=6", n); end
    wr(TST, 1, 0); #1;
    total++; if (timer_irq !== 0) begin bad++; $display("FAIL irq_clear got=%b exp=0", timer_irq); end
    wr(CNT, 32'hFFFF_FFF0, 0);
    n = 0;
    while (n < 60) begin
      drive(0, CNT, 0, 0);
      tick(); n++;
      if (timer_irq) break;
    end
    total++; if (n !== 37) begin bad++; $display("FAIL irq_wrap got=%0d exp=37", n); end
    wr(TST, 1, 0);
    wr(CNT, 18, 0);
    drive(0, CNT, 0, 0); tick();
    drive(0, CNT, 0, 0); tick();
    wr(TST, 1, 0); #1;
    total++; if (timer_irq !== 1) begin bad++; $display("FAIL set_beats_clear got=%b exp=1", timer_irq); end
    total++; if (timer_irq !== m_flag) begin bad++; $display("FAIL irq_model got=%b exp=%b", timer_irq, m_flag); end
  endtask

  task automatic test_fifo_overflow();
    for (int i = 0; i < 4; i++) wr(TXD, 32'h41 + i, 0);
    drive(0, TXS, 0, 0); #1;
    total++; if (rd_data !== 32'h41) begin bad++; $display("FAIL txstat_full got=%h exp=41", rd_data); end
    wr(TXD, 32'h45, 0);
    drive(0, TXS, 0, 0); #1;
    total++; if (rd_data !== 32'h45) begin bad++; $display("FAIL txstat_ovf got=%h exp=45", rd_data); end
    for (int i = 0; i < 4; i++) begin
      drive(0, TXS, 0, 1); #1;
      total++; if (tx_valid !== 1 || tx_data !== 8'(8'h41 + i)) begin bad++; $display("FAIL drain v=%b got=%h exp=%h", tx_valid, tx_data, 8'(8'h41 + i)); end
      tick();
    end
    drive(0, TXS, 0, 0); #1;
    total++; if (tx_valid !== 0) begin bad++; $display("FAIL drained_valid got=%b exp=0", tx_valid); end
    total++; if (rd_data !== 32'h06) begin bad++; $display("FAIL txstat_empty got=%h exp=06", rd_data); end
    wr(TXS, 4, 0);
    drive(0, TXS, 0, 0); #1;
    total++; if (rd_data !== 32'h02) begin bad++; $display("FAIL ovf_clear got=%h exp=02", rd_data); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_q [4];
    exp_q = '{8'h12, 8'h13, 8'h14, 8'h55};
    for (int i = 0; i < 4; i++) wr(TXD, 32'h11 + i, 0);
    drive(1, TXD, 32'h55, 1); #1;
    total++; if (tx_data !== 8'h11) begin bad++; $display("FAIL b2b_head got=%h exp=11", tx_data); end
    tick();
    drive(0, TXS, 0, 0); #1;
    total++; if (rd_data !== 32'h41) begin bad++; $display("FAIL b2b_txstat got=%h exp=41", rd_data); end
    for (int i = 0; i < 4; i++) begin
      drive(0, TXS, 0, 1); #1;
      total++; if (tx_valid !== 1 || tx_data !== exp_q[i]) begin bad++; $display("FAIL b2b_drain v=%b got=%h exp=%h", tx_valid, tx_data, exp_q[i]); end
      tick();
    end
    #1;
    total++; if (tx_valid !== 0) begin bad++; $display("FAIL b2b_empty got=%b exp=0", tx_valid); end
  endtask

  task automatic test_random();
    logic [31:0] a, d;
    bit w, r;
    for (int i = 0; i < 400; i++) begin
      w = $urandom_range(0, 1);
      r = $urandom_range(0, 2) == 0;
      a = $urandom_range(0, 9) < 4 ? ($urandom & 32'h7FFF_FFFF) : (32'h8000_0000 | $urandom_range(0, 31));
      d = $urandom;
      if (a[31] && (a % 32) / 4 == 2) d = m_count + $urandom_range(1, 8);
      drive(w, a, d, r); #1;
      total++; if (rd_data !== exp_rd(a)) begin bad++; $display("FAIL rand_rd a=%h got=%h exp=%h", a, rd_data, exp_rd(a)); end
      total++; if (tx_valid !== (mq.size() > 0) || tx_data !== (mq.size() > 0 ? mq[0] : 8'h00)) begin bad++; $display("FAIL rand_tx v=%b d=%h exp_n=%0d", tx_valid, tx_data, mq.size()); end
      tick(); #1;
      total++; if (led !== m_led || timer_irq !== m_flag) begin bad++; $display("FAIL rand_out led=%h/%h irq=%b/%b", led, m_led, timer_irq, m_flag); end
    end
  endtask

  task automatic test_reset_mid();
    wr(CMP, 100, 0);
    wr(CNT, 100, 0);
    drive(0, CNT, 0, 0); tick();
    wr(LED, 32'h3C, 0);
    for (int i = 0; i < 8 && mq.size() > 0; i++) begin drive(0, TXS, 0, 1); tick(); end
    for (int i = 0; i < 3; i++) wr(TXD, 32'h61 + i, 0);
    drive(0, 32'h10, 0, 1); tick();
    #1;
    total++; if (tx_valid !== 1 || led !== 32'h3C || timer_irq !== 1) begin bad++; $display("FAIL premid v=%b led=%h irq=%b", tx_valid, led, timer_irq); end
    #1 reset = 0; #1;
    model_reset();
    total++; if (tx_valid !== 0) begin bad++; $display("FAIL mid_txv got=%b exp=0", tx_valid); end
    total++; if (led !== 0) begin bad++; $display("FAIL mid_led got=%h exp=0", led); end
    total++; if (timer_irq !== 0) begin bad++; $display("FAIL mid_irq got=%b exp=0", timer_irq); end
    total++; if (tx_data !== 0) begin bad++; $display("FAIL mid_txd got=%h exp=0", tx_data); end
    total++; if (rd_data !== mram[4]) begin bad++; $display("FAIL mid_ram got=%h exp=%h", rd_data, mram[4]); end
    @(negedge clk);
    reset = 1;
  endtask

  initial begin
    test_reset();
    test_ram();
    test_led();
    test_timer();
    test_fifo_overflow();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
